pipe_alu_fwd: RTL and testbench

PIPE_ALU_FWD -- requirements
Module: pipe_alu_fwd

---
 rtl/pipe_alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 34 +++
 rtl/pipe_alu_fwd.sv | 140 ++++++++++++++
 tb/tb_pipe_alu_fwd.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_pkg.sv
// Shared definitions for the forwarding ALU pipeline: default sizes and
// the operation encoding used by both the pipeline and the ALU core.
package pipe_alu_pkg;

    // Default datapath width, register-bank depth and data-memory depth
    localparam int DEF_W      = 16;
    localparam int DEF_NREG   = 16;
    localparam int DEF_MDEPTH = 256;

    // Operation codes; 12..15 are unassigned and produce zero
    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_MUL   = 4'd2,
        FN_PASSA = 4'd3,
        FN_PASSB = 4'd4,
        FN_AND   = 4'd5,
        FN_OR    = 4'd6,
        FN_XOR   = 4'd7,
        FN_NOTA  = 4'd8,
        FN_NOTB  = 4'd9,
        FN_SHR   = 4'd10,
        FN_SHL   = 4'd11
    } func_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational W-bit ALU. Every result wraps modulo 2^W and no
// status flags are produced; unassigned operation codes give zero.
module alu_core
    import pipe_alu_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   func_i,
    output logic [W-1:0] y_o
);

    // Select the operation; the product keeps only its low W bits
    always_comb begin
        y_o = '0;
        case (func_i)
            FN_ADD:   y_o = a_i + b_i;
            FN_SUB:   y_o = a_i - b_i;
            FN_MUL:   y_o = a_i * b_i;
            FN_PASSA: y_o = a_i;
            FN_PASSB: y_o = b_i;
            FN_AND:   y_o = a_i & b_i;
            FN_OR:    y_o = a_i | b_i;
            FN_XOR:   y_o = a_i ^ b_i;
            FN_NOTA:  y_o = ~a_i;
            FN_NOTB:  y_o = ~b_i;
            FN_SHR:   y_o = a_i >> 1;
            FN_SHL:   y_o = a_i << 1;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_alu_fwd.sv
// Four-stage ALU pipeline with operand forwarding.
//   S1: operands (already forwarded), rd, func, addr latched on acceptance
//   S2: ALU result registered into Z, presented with out_valid/out_rd
//   S3: register bank written from Z; result carried on for memory
//   S4: data memory written with the result
// A single ALU instance evaluates the S1 instruction; its output both feeds
// the S1 forward path and becomes Z on the next edge.
module pipe_alu_fwd
    import pipe_alu_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int NREG   = DEF_NREG,
    parameter int MDEPTH = DEF_MDEPTH,
    localparam int RW    = $clog2(NREG),
    localparam int AW    = $clog2(MDEPTH)
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rd,
    input  logic [3:0]    func,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] mem_raddr,
    output logic [W-1:0]  Z,
    output logic          out_valid,
    output logic [RW-1:0] out_rd,
    output logic [W-1:0]  mem_rdata
);

    // Stage 1 registers
    logic          s1Valid_q;
    logic [W-1:0]  s1A_q;
    logic [W-1:0]  s1B_q;
    logic [RW-1:0] s1Rd_q;
    logic [3:0]    s1Func_q;
    logic [AW-1:0] s1Addr_q;

    // Stage 2 registers
    logic          s2Valid_q;
    logic [W-1:0]  z_q;
    logic [RW-1:0] s2Rd_q;
    logic [AW-1:0] s2Addr_q;

    // Stage 3 registers
    logic          s3Valid_q;
    logic [W-1:0]  s3Data_q;
    logic [AW-1:0] s3Addr_q;

    // Architectural state
    logic [W-1:0]  regbank_q [NREG];
    logic [W-1:0]  mem_q [MDEPTH];

    // Forwarded operands for the instruction being accepted
    logic [W-1:0]  opA_d;
    logic [W-1:0]  opB_d;
    logic [W-1:0]  s1Result;

    alu_core #(
        .W (W)
    ) u_alu (
        .a_i    (s1A_q),
        .b_i    (s1B_q),
        .func_i (s1Func_q),
        .y_o    (s1Result)
    );

    // Operand selection: the youngest in-flight producer of a register wins.
    // The S2 forward also covers the regbank write happening on this same
    // edge, since that write is not yet visible in regbank_q.
    always_comb begin
        opA_d = regbank_q[rs1];
        opB_d = regbank_q[rs2];
        if (s2Valid_q && (s2Rd_q == rs1)) opA_d = z_q;
        if (s2Valid_q && (s2Rd_q == rs2)) opB_d = z_q;
        if (s1Valid_q && (s1Rd_q == rs1)) opA_d = s1Result;
        if (s1Valid_q && (s1Rd_q == rs2)) opB_d = s1Result;
    end

    // Pipeline advance and regbank write; reset drops every in-flight
    // instruction and restores regbank[k] = k
    always_ff @(posedge clk1) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Rd_q    <= '0;
            s1Func_q  <= '0;
            s1Addr_q  <= '0;
            s2Valid_q <= 1'b0;
            z_q       <= '0;
            s2Rd_q    <= '0;
            s2Addr_q  <= '0;
            s3Valid_q <= 1'b0;
            s3Data_q  <= '0;
            s3Addr_q  <= '0;
            for (int k = 0; k < NREG; k++) begin
                regbank_q[k] <= W'(k);
            end
        end else begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1A_q    <= opA_d;
                s1B_q    <= opB_d;
                s1Rd_q   <= rd;
                s1Func_q <= func;
                s1Addr_q <= addr;
            end

            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                z_q      <= s1Result;
                s2Rd_q   <= s1Rd_q;
                s2Addr_q <= s1Addr_q;
            end

            s3Valid_q <= s2Valid_q;
            if (s2Valid_q) begin
                s3Data_q           <= z_q;
                s3Addr_q           <= s2Addr_q;
                regbank_q[s2Rd_q]  <= z_q;
            end
        end
    end

    // Data memory write from the last stage; contents survive reset but a
    // reset edge suppresses the write of the instruction being dropped
    always_ff @(posedge clk1) begin
        if (!rst && s3Valid_q) begin
            mem_q[s3Addr_q] <= s3Data_q;
        end
    end

    assign Z         = z_q;
    assign out_valid = s2Valid_q;
    assign out_rd    = s2Rd_q;
    assign mem_rdata = mem_q[mem_raddr];

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Directed self-checking bench for pipe_alu_fwd. Expected results are queued
// with the cycle they are due and compared when the DUT presents them.
module tb_pipe_alu_fwd;
    import pipe_alu_pkg::*;

    logic        clk1;
    logic        rst;
    logic        in_valid;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [7:0]  mem_raddr;
    logic [15:0] Z;
    logic        out_valid;
    logic [3:0]  out_rd;
    logic [15:0] mem_rdata;

    typedef struct {
        string       tag;
        logic [15:0] z;
        logic [3:0]  rd;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    pipe_alu_fwd dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .mem_raddr (mem_raddr),
        .Z         (Z),
        .out_valid (out_valid),
        .out_rd    (out_rd),
        .mem_rdata (mem_rdata)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock edge, then compare outputs at the falling edge
    task automatic stepClock();
        exp_t e;
        logic expV;
        @(posedge clk1);
        cyc++;
        @(negedge clk1);
        expV = (q.size() > 0) && (q[0].due == cyc);
        checkOutput("out_valid", 32'(out_valid), 32'(expV));
        if (expV) begin
            e = q.pop_front();
            checkOutput({e.tag, "_Z"}, 32'(Z), 32'(e.z));
            checkOutput({e.tag, "_rd"}, 32'(out_rd), 32'(e.rd));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] d, input logic [3:0] f,
                                 input logic [7:0] ad, input logic [15:0] expZ);
        exp_t e;
        in_valid = v;
        rs1      = a;
        rs2      = b;
        rd       = d;
        func     = f;
        addr     = ad;
        if (v) begin
            e.tag = tag;
            e.z   = expZ;
            e.rd  = d;
            e.due = cyc + 2;
            q.push_back(e);
        end
        stepClock();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus("bubble", 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkMem(input string tag, input logic [7:0] a, input logic [15:0] expD);
        mem_raddr = a;
        #1;
        checkOutput(tag, 32'(mem_rdata), 32'(expD));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs1 = 0; rs2 = 0; rd = 0; func = 0;
        addr = 0; mem_raddr = 0;
        $display("[TB] reset");
        stepClock();
        stepClock();
        checkOutput("rst_Z", 32'(Z), 32'h0);
        checkOutput("rst_out_rd", 32'(out_rd), 32'h0);
        rst = 1'b0;

        // Back-to-back dependent chain through the S1 forward path
        applyStimulus("chain_add", 1, 3, 5, 10, FN_ADD, 8'd1, 16'd8);
        applyStimulus("chain_sub", 1, 10, 5, 14, FN_SUB, 8'd1, 16'd3);
        applyStimulus("chain_mul", 1, 14, 3, 12, FN_MUL, 8'd1, 16'd9);
        drain(4);

        // Basic ADD with result to register and memory
        applyStimulus("add_basic", 1, 3, 5, 10, FN_ADD, 8'd125, 16'd8);
        drain(4);
        checkMem("mem125", 8'd125, 16'd8);
        applyStimulus("read_r10", 1, 10, 0, 14, FN_PASSA, 8'd1, 16'd8);
        drain(2);

        // S2 forward on the regbank-write edge
        applyStimulus("fwd2_a", 1, 1, 2, 4, FN_ADD, 8'd1, 16'd3);
        drain(1);
        applyStimulus("fwd2_b", 1, 4, 4, 6, FN_ADD, 8'd1, 16'd6);
        drain(2);

        // Wrap-around, logical shift right, unassigned opcode
        applyStimulus("sub_wrap", 1, 0, 1, 7, FN_SUB, 8'd1, 16'hFFFF);
        applyStimulus("shr", 1, 7, 0, 8, FN_SHR, 8'd1, 16'h7FFF);
        applyStimulus("func13", 1, 7, 7, 11, 4'd13, 8'd1, 16'h0000);
        drain(3);

        // Two in-flight writes to r9: younger wins
        applyStimulus("r9_old", 1, 2, 0, 9, FN_PASSA, 8'd1, 16'd2);
        applyStimulus("r9_new", 1, 3, 0, 9, FN_PASSA, 8'd1, 16'd3);
        applyStimulus("r9_use", 1, 9, 0, 13, FN_ADD, 8'd1, 16'd3);
        drain(3);

        // Remaining operations with A=r15 (0x000F), B=r5 (0x0005)
        applyStimulus("and",   1, 15, 5, 11, FN_AND,   8'd1, 16'h0005);
        applyStimulus("or",    1, 15, 5, 11, FN_OR,    8'd1, 16'h000F);
        applyStimulus("xor",   1, 15, 5, 11, FN_XOR,   8'd1, 16'h000A);
        applyStimulus("nota",  1, 15, 5, 11, FN_NOTA,  8'd1, 16'hFFF0);
        applyStimulus("notb",  1, 15, 5, 11, FN_NOTB,  8'd1, 16'hFFFA);
        applyStimulus("shl",   1, 15, 5, 11, FN_SHL,   8'd1, 16'h001E);
        applyStimulus("passb", 1, 15, 5, 11, FN_PASSB, 8'd1, 16'h0005);
        applyStimulus("mul",   1, 15, 5, 11, FN_MUL,   8'd1, 16'h004B);
        applyStimulus("mul_trunc", 1, 7, 7, 12, FN_MUL, 8'd1, 16'h0001);
        applyStimulus("add_wrap",  1, 7, 1, 12, FN_ADD, 8'd1, 16'h0000);
        drain(3);

        // rs1 == rs2 forwarded identically from S1
        applyStimulus("same_a", 1, 3, 3, 13, FN_ADD, 8'd1, 16'd6);
        applyStimulus("same_b", 1, 13, 13, 13, FN_ADD, 8'd1, 16'd12);
        drain(3);

        // Consecutive memory writes to one address: younger stays
        applyStimulus("mem_old", 1, 3, 5, 12, FN_ADD, 8'd50, 16'd8);
        applyStimulus("mem_new", 1, 3, 5, 12, FN_SUB, 8'd50, 16'hFFFE);
        drain(4);
        checkMem("mem50", 8'd50, 16'hFFFE);

        // Reset mid-flight drops everything, including the rst-edge input
        applyStimulus("pre200", 1, 15, 0, 10, FN_PASSA, 8'd200, 16'h000F);
        drain(4);
        checkMem("mem200_pre", 8'd200, 16'h000F);
        applyStimulus("dropped", 1, 3, 5, 10, FN_ADD, 8'd200, 16'd8);
        q.delete();
        rst = 1'b1;
        in_valid = 1'b1; rs1 = 3; rs2 = 5; rd = 5; func = FN_ADD; addr = 8'd200;
        stepClock();
        rst = 1'b0;
        in_valid = 1'b0;
        drain(4);
        checkMem("mem200_post", 8'd200, 16'h000F);
        applyStimulus("r10_reset", 1, 10, 0, 1, FN_PASSA, 8'd1, 16'd10);
        applyStimulus("r5_reset", 1, 5, 0, 2, FN_PASSA, 8'd1, 16'd5);
        drain(3);

        checkOutput("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
